// File: rtl/biquad_intercon_pkg.sv
// Shared types and constants for the biquad cascade Wishbone intercon.
package biquad_intercon_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StResp
  } state_e;

  typedef enum logic [1:0] {
    RespAck,
    RespErr,
    RespRty
  } resp_e;

  localparam logic [1:0] CsrBypass = 2'd0;
  localparam logic [1:0] CsrUpdate = 2'd1;
  localparam logic [1:0] CsrStatus = 2'd2;
  localparam logic [1:0] CsrId     = 2'd3;

  localparam logic [15:0] CsrIdValue = 16'hB18C;

  // Expand Wishbone byte selects into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/biquad_intercon_csr.sv
// Local CSR page: bypass mask, update strobe, timeout status (BQ_INTERCON_TIMEOUT_EN), ID.
module biquad_intercon_csr
  import biquad_intercon_pkg::*;
#(
  parameter int unsigned NSTAGE = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              access_i,
  input  logic              we_i,
  input  logic [1:0]        off_i,
  input  logic [31:0]       wdat_i,
  input  logic [3:0]        sel_i,
  input  logic              to_log_i,
  input  logic [3:0]        to_stage_i,
  output logic [31:0]       rdata_o,
  output logic [NSTAGE-1:0] bypass_o,
  output logic              update_o
);

  logic [31:0]       wmask;
  logic              wr;
  logic [NSTAGE-1:0] bypass_d, bypass_q;
  logic              upd_pend_d, upd_pend_q, update_q;
  logic [15:0]       to_cnt_d, to_cnt_q;
  logic [3:0]        to_stage_d, to_stage_q;
  logic              unused_wdat;

  assign wmask       = lane_mask(sel_i);
  assign wr          = access_i & we_i;
  assign unused_wdat = ^wdat_i;

  always_comb begin
    bypass_d = bypass_q;
    if (wr && off_i == CsrBypass) begin
      bypass_d = (bypass_q & ~wmask[NSTAGE-1:0]) | (wdat_i[NSTAGE-1:0] & wmask[NSTAGE-1:0]);
    end
  end

  // Pending bit is high during RESP, so the visible pulse lands the cycle after it.
  assign upd_pend_d = wr && (off_i == CsrUpdate) && wmask[0] && wdat_i[0];

`ifdef BQ_INTERCON_TIMEOUT_EN
  logic [19:0] clr;

  always_comb begin
    clr        = (wr && off_i == CsrStatus) ? (wdat_i[19:0] & wmask[19:0]) : '0;
    to_cnt_d   = to_cnt_q & ~clr[15:0];
    to_stage_d = to_stage_q & ~clr[19:16];
    if (to_log_i) begin
      to_cnt_d   = (to_cnt_q == 16'hFFFF) ? to_cnt_q : to_cnt_q + 16'd1;
      to_stage_d = to_stage_i;
    end
  end
`else
  logic unused_to;

  assign unused_to  = to_log_i ^ (^to_stage_i);
  assign to_cnt_d   = '0;
  assign to_stage_d = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bypass_q   <= '0;
      upd_pend_q <= 1'b0;
      update_q   <= 1'b0;
      to_cnt_q   <= '0;
      to_stage_q <= '0;
    end else begin
      bypass_q   <= bypass_d;
      upd_pend_q <= upd_pend_d;
      update_q   <= upd_pend_q;
      to_cnt_q   <= to_cnt_d;
      to_stage_q <= to_stage_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (off_i)
      CsrBypass: rdata_o[NSTAGE-1:0] = bypass_q;
      CsrStatus: rdata_o = {12'd0, to_stage_q, to_cnt_q};
      CsrId:     rdata_o = {CsrIdValue, 12'd0, 4'(NSTAGE)};
      default:   rdata_o = '0;
    endcase
  end

  assign bypass_o = bypass_q;
  assign update_o = update_q;

endmodule

// File: rtl/biquad_cascade_wb_intercon.sv
// Registered classic-WB fan-out to NSTAGE biquad coefficient slaves plus a local CSR page.
// Optional slave timeout enabled by defining BQ_INTERCON_TIMEOUT_EN.
module biquad_cascade_wb_intercon
  import biquad_intercon_pkg::*;
#(
  parameter int unsigned NSTAGE  = 4,
  parameter int unsigned SLV_AW  = 7,
  parameter int unsigned ADR_W   = 22,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [ADR_W-1:0]    wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic                wb_rty_o,
  output logic [31:0]         wb_dat_o,
  output logic [NSTAGE-1:0]   s_cyc_o,
  output logic [NSTAGE-1:0]   s_stb_o,
  output logic [SLV_AW-1:0]   s_adr_o,
  output logic [31:0]         s_dat_o,
  output logic                s_we_o,
  output logic [3:0]          s_sel_o,
  input  logic [NSTAGE*32-1:0] s_dat_i,
  input  logic [NSTAGE-1:0]   s_ack_i,
  input  logic [NSTAGE-1:0]   s_err_i,
  input  logic [NSTAGE-1:0]   s_rty_i,
  output logic [NSTAGE-1:0]   bypass_o,
  output logic                update_o
);

  localparam int unsigned SEL_W = $clog2(NSTAGE + 1);

  state_e            state_d, state_q;
  resp_e             resp_d, resp_q;
  logic [SEL_W-1:0]  page_in, page_d, page_q;
  logic [SLV_AW-1:0] adr_d, adr_q;
  logic [31:0]       wdat_d, wdat_q, rdat_d, rdat_q;
  logic              we_d, we_q;
  logic [3:0]        sel_d, sel_q;
  logic [NSTAGE-1:0] stage_oh;
  logic [31:0]       stage_dat, csr_rdata;
  logic              is_csr, csr_access, to_log, timeout_hit;
  logic              rsp_ack, rsp_err, rsp_rty;
  logic              unused_adr;

  assign page_in    = wb_adr_i[SLV_AW +: SEL_W];
  assign is_csr     = (page_q == SEL_W'(NSTAGE));
  assign unused_adr = ^wb_adr_i;

  always_comb begin
    stage_oh  = '0;
    stage_dat = '0;
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      if (page_q == SEL_W'(k)) begin
        stage_oh[k] = 1'b1;
        stage_dat   = s_dat_i[32*k +: 32];
      end
    end
  end

  assign rsp_ack = |(s_ack_i & stage_oh);
  assign rsp_err = |(s_err_i & stage_oh);
  assign rsp_rty = |(s_rty_i & stage_oh);

`ifdef BQ_INTERCON_TIMEOUT_EN
  logic [15:0] cnt_d, cnt_q;

  // Counter value k means k+1 ACTIVE cycles have elapsed by the next edge.
  assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));
  assign cnt_d       = (state_q == StActive && !is_csr) ? cnt_q + 16'd1 : '0;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [15:0] unused_timeout;

  assign unused_timeout = 16'(TIMEOUT);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    resp_d     = resp_q;
    page_d     = page_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    rdat_d     = rdat_q;
    we_d       = we_q;
    sel_d      = sel_q;
    csr_access = 1'b0;
    to_log     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wb_cyc_i && wb_stb_i) begin
          page_d = page_in;
          adr_d  = wb_adr_i[SLV_AW-1:0];
          wdat_d = wb_dat_i;
          we_d   = wb_we_i;
          sel_d  = wb_sel_i;
          rdat_d = '0;
          if (32'(page_in) > NSTAGE) begin
            resp_d  = RespErr;
            state_d = StResp;
          end else begin
            state_d = StActive;
          end
        end
      end
      StActive: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else if (is_csr) begin
          csr_access = 1'b1;
          rdat_d     = csr_rdata;
          resp_d     = RespAck;
          state_d    = StResp;
        end else if (rsp_err || rsp_rty || rsp_ack) begin
          rdat_d  = stage_dat;
          resp_d  = rsp_err ? RespErr : (rsp_rty ? RespRty : RespAck);
          state_d = StResp;
        end else if (timeout_hit) begin
          to_log  = 1'b1;
          resp_d  = RespErr;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= StIdle;
      resp_q  <= RespAck;
      page_q  <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      page_q  <= page_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
    end
  end

  biquad_intercon_csr #(
    .NSTAGE(NSTAGE)
  ) u_csr (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_n_i),
    .access_i  (csr_access),
    .we_i      (we_q),
    .off_i     (adr_q[1:0]),
    .wdat_i    (wdat_q),
    .sel_i     (sel_q),
    .to_log_i  (to_log),
    .to_stage_i(4'(page_q)),
    .rdata_o   (csr_rdata),
    .bypass_o  (bypass_o),
    .update_o  (update_o)
  );

  assign wb_ack_o = (state_q == StResp) && (resp_q == RespAck);
  assign wb_err_o = (state_q == StResp) && (resp_q == RespErr);
  assign wb_rty_o = (state_q == StResp) && (resp_q == RespRty);
  assign wb_dat_o = (state_q == StResp) ? rdat_q : '0;

  assign s_cyc_o = (state_q == StActive) ? stage_oh : '0;
  assign s_stb_o = (state_q == StActive) ? stage_oh : '0;
  assign s_adr_o = adr_q;
  assign s_dat_o = wdat_q;
  assign s_we_o  = we_q;
  assign s_sel_o = sel_q;

endmodule

// File: tb/tb_biquad_cascade_wb_intercon.sv
// Directed table-driven bench for biquad_cascade_wb_intercon (NSTAGE=4, TIMEOUT=8).
module tb_biquad_cascade_wb_intercon;

  localparam int KAck    = 0;
  localparam int KErr    = 1;
  localparam int KRty    = 2;
  localparam int KAckErr = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wb_cyc_i, wb_stb_i, wb_we_i;
  logic [21:0]  wb_adr_i;
  logic [31:0]  wb_dat_i;
  logic [3:0]   wb_sel_i;
  logic         wb_ack_o, wb_err_o, wb_rty_o;
  logic [31:0]  wb_dat_o;
  logic [3:0]   s_cyc_o, s_stb_o;
  logic [6:0]   s_adr_o;
  logic [31:0]  s_dat_o;
  logic         s_we_o;
  logic [3:0]   s_sel_o;
  logic [127:0] s_dat_i;
  logic [3:0]   s_ack_i, s_err_i, s_rty_i;
  logic [3:0]   bypass_o;
  logic         update_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  biquad_cascade_wb_intercon #(
    .NSTAGE (4),
    .SLV_AW (7),
    .ADR_W  (22),
    .TIMEOUT(8)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .wb_cyc_i  (wb_cyc_i),
    .wb_stb_i  (wb_stb_i),
    .wb_we_i   (wb_we_i),
    .wb_adr_i  (wb_adr_i),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_i  (wb_sel_i),
    .wb_ack_o  (wb_ack_o),
    .wb_err_o  (wb_err_o),
    .wb_rty_o  (wb_rty_o),
    .wb_dat_o  (wb_dat_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_we_o    (s_we_o),
    .s_sel_o   (s_sel_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .s_rty_i   (s_rty_i),
    .bypass_o  (bypass_o),
    .update_o  (update_o)
  );

  typedef struct {
    logic [2:0]  page;
    logic [6:0]  off;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          dly;     // slave reply delay after s_stb_o rises, -1 = never
    int          kind;
    logic [2:0]  exp_rsp; // {rty, err, ack}
    int          exp_lat; // cycles from request sample to response
    logic        chk_dat;
    logic [31:0] exp_dat;
    logic [3:0]  exp_byp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  // One bounded classic-WB transaction with a bench-driven slave on the addressed stage.
  task automatic run_txn(input logic [2:0] page, input logic [6:0] off, input logic we,
                         input logic [31:0] dat, input logic [3:0] sel, input int dly,
                         input int kind, input int max_cyc, output logic [2:0] rtype,
                         output logic [31:0] rdat, output int lat, output logic bus_ok);
    int rise;
    rise   = -1;
    rtype  = 3'b000;
    rdat   = '0;
    lat    = -1;
    bus_ok = 1'b1;
    wb_adr_i = {12'd0, page, off};
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(posedge clk);
      #1;
      s_ack_i = '0;
      s_err_i = '0;
      s_rty_i = '0;
      if (s_cyc_o != 4'd0 || s_stb_o != 4'd0) begin
        if (page >= 3'd4 || s_stb_o != (4'b0001 << page) || s_cyc_o != s_stb_o ||
            s_adr_o != off || s_we_o != we || s_dat_o != dat || s_sel_o != sel) bus_ok = 1'b0;
        if (rise < 0) rise = c;
      end
      if (wb_ack_o || wb_err_o || wb_rty_o) begin
        rtype = {wb_rty_o, wb_err_o, wb_ack_o};
        rdat  = wb_dat_o;
        lat   = c;
        break;
      end
      if (wb_dat_o != 32'd0) bus_ok = 1'b0;
      if (rise >= 0 && dly >= 0 && c - rise == dly && page < 3'd4) begin
        case (kind)
          KAck:    s_ack_i[page[1:0]] = 1'b1;
          KErr:    s_err_i[page[1:0]] = 1'b1;
          KRty:    s_rty_i[page[1:0]] = 1'b1;
          default: begin
            s_ack_i[page[1:0]] = 1'b1;
            s_err_i[page[1:0]] = 1'b1;
          end
        endcase
      end
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    s_ack_i  = '0;
    s_err_i  = '0;
    s_rty_i  = '0;
    idle_cycle();
  endtask

  // Convenience wrapper: transaction plus response/latency/data checks.
  task automatic txn_chk(input string name, input logic [2:0] page, input logic [6:0] off,
                         input logic we, input logic [31:0] dat, input int dly, input int kind,
                         input logic [2:0] exp_rsp, input int exp_lat, input logic chk_dat,
                         input logic [31:0] exp_dat);
    logic [2:0]  rt;
    logic [31:0] rd;
    int          lt;
    logic        ok;
    run_txn(page, off, we, dat, 4'hF, dly, kind, 20, rt, rd, lt, ok);
    check({name, "_rsp"}, 32'(rt), 32'(exp_rsp));
    check({name, "_lat"}, lt, exp_lat);
    if (chk_dat) check({name, "_dat"}, rd, exp_dat);
  endtask

  initial begin
    logic [2:0]  rt;
    logic [31:0] rd;
    int          lt;
    logic        ok;
    int          resp_seen;
    int          upd_cnt, upd_at, ack_at;

    vecs[0]  = '{3'd2, 7'd5,    1'b1, 32'hDEADBEEF, 4'hF,    3, KAck,    3'b001, 5, 1'b1,
                 32'hA0A00002, 4'b0000};
    vecs[1]  = '{3'd4, 7'd3,    1'b0, 32'h0,        4'hF,   -1, KAck,    3'b001, 2, 1'b1,
                 32'hB18C0004, 4'b0000};
    vecs[2]  = '{3'd4, 7'd0,    1'b1, 32'hA,        4'b0001, -1, KAck,   3'b001, 2, 1'b0,
                 32'h0,        4'b1010};
    vecs[3]  = '{3'd4, 7'd0,    1'b0, 32'h0,        4'hF,   -1, KAck,    3'b001, 2, 1'b1,
                 32'h0000000A, 4'b1010};
    vecs[4]  = '{3'd7, 7'd0,    1'b0, 32'h0,        4'hF,   -1, KAck,    3'b010, 1, 1'b1,
                 32'h0,        4'b1010};
    vecs[5]  = '{3'd5, 7'd9,    1'b1, 32'h1234,     4'hF,   -1, KAck,    3'b010, 1, 1'b1,
                 32'h0,        4'b1010};
    vecs[6]  = '{3'd0, 7'h7F,   1'b0, 32'h0,        4'hF,    0, KRty,    3'b100, 2, 1'b1,
                 32'hA0A00000, 4'b1010};
    vecs[7]  = '{3'd3, 7'd1,    1'b0, 32'h0,        4'hF,    1, KAckErr, 3'b010, 3, 1'b1,
                 32'hA0A00003, 4'b1010};
    vecs[8]  = '{3'd1, 7'd2,    1'b1, 32'h55AA,     4'h3,    2, KErr,    3'b010, 4, 1'b1,
                 32'hA0A00001, 4'b1010};
    vecs[9]  = '{3'd4, 7'd1,    1'b0, 32'h0,        4'hF,   -1, KAck,    3'b001, 2, 1'b1,
                 32'h0,        4'b1010};
    vecs[10] = '{3'd4, 7'd0,    1'b1, 32'hFFFFFF05, 4'b1110, -1, KAck,   3'b001, 2, 1'b0,
                 32'h0,        4'b1010};
    vecs[11] = '{3'd4, 7'h7B,   1'b0, 32'h0,        4'hF,   -1, KAck,    3'b001, 2, 1'b1,
                 32'hB18C0004, 4'b1010};
    vecs[12] = '{3'd4, 7'd2,    1'b0, 32'h0,        4'hF,   -1, KAck,    3'b001, 2, 1'b1,
                 32'h0,        4'b1010};

    rst_n    = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_sel_i = '0;
    s_ack_i  = '0;
    s_err_i  = '0;
    s_rty_i  = '0;
    s_dat_i  = {32'hA0A00003, 32'hA0A00002, 32'hA0A00001, 32'hA0A00000};

    repeat (3) idle_cycle();
    check("reset_ctrl", {4'd0, s_adr_o, s_we_o, s_sel_o, wb_ack_o, wb_err_o, wb_rty_o,
                         s_cyc_o, s_stb_o, bypass_o, update_o}, 32'd0);
    check("reset_wbdat", wb_dat_o, 32'd0);
    check("reset_sdat", s_dat_o, 32'd0);
    rst_n = 1'b1;
    idle_cycle();

    for (int i = 0; i < 13; i++) begin
      run_txn(vecs[i].page, vecs[i].off, vecs[i].we, vecs[i].dat, vecs[i].sel, vecs[i].dly,
              vecs[i].kind, 20, rt, rd, lt, ok);
      check($sformatf("v%0d_rsp", i), 32'(rt), 32'(vecs[i].exp_rsp));
      check($sformatf("v%0d_lat", i), lt, vecs[i].exp_lat);
      if (vecs[i].chk_dat) check($sformatf("v%0d_dat", i), rd, vecs[i].exp_dat);
      check($sformatf("v%0d_bus", i), 32'(ok), 32'd1);
      check($sformatf("v%0d_bypass", i), 32'(bypass_o), 32'(vecs[i].exp_byp));
    end

    // Upstream abort mid-ACTIVE: slave strobe drops next edge, no response.
    wb_adr_i = {12'd0, 3'd3, 7'd4};
    wb_we_i  = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    repeat (2) idle_cycle();
    check("abort_active_cyc", 32'(s_cyc_o), 32'b1000);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    idle_cycle();
    check("abort_cyc_drop", 32'({s_cyc_o, s_stb_o}), 32'd0);
    resp_seen = 0;
    repeat (3) begin
      if (wb_ack_o || wb_err_o || wb_rty_o) resp_seen++;
      idle_cycle();
    end
    check("abort_no_resp", resp_seen, 0);

`ifdef BQ_INTERCON_TIMEOUT_EN
    txn_chk("to_err", 3'd1, 7'd0, 1'b0, 32'h0, -1, KAck, 3'b010, 9, 1'b0, 32'h0);
    txn_chk("to_csr2", 3'd4, 7'd2, 1'b0, 32'h0, -1, KAck, 3'b001, 2, 1'b1, 32'h00010001);
    txn_chk("to_w1c", 3'd4, 7'd2, 1'b1, 32'h1, -1, KAck, 3'b001, 2, 1'b0, 32'h0);
    txn_chk("to_cleared", 3'd4, 7'd2, 1'b0, 32'h0, -1, KAck, 3'b001, 2, 1'b1, 32'h00010000);
    // Reply sampled on the same edge the count expires: the reply wins.
    txn_chk("to_race", 3'd1, 7'd0, 1'b0, 32'h0, 7, KAck, 3'b001, 9, 1'b1, 32'hA0A00001);
    txn_chk("to_race_csr2", 3'd4, 7'd2, 1'b0, 32'h0, -1, KAck, 3'b001, 2, 1'b1, 32'h00010000);
`else
    wb_adr_i = {12'd0, 3'd1, 7'd0};
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    resp_seen = 0;
    repeat (20) begin
      idle_cycle();
      if (wb_ack_o || wb_err_o || wb_rty_o) resp_seen++;
    end
    check("nto_wait_resp", resp_seen, 0);
    check("nto_still_active", 32'(s_cyc_o), 32'b0010);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    repeat (2) idle_cycle();
    txn_chk("nto_csr2", 3'd4, 7'd2, 1'b0, 32'h0, -1, KAck, 3'b001, 2, 1'b1, 32'h0);
`endif

    // Reset asserted mid-ACTIVE clears outputs and the bypass mask.
    wb_adr_i = {12'd0, 3'd2, 7'd9};
    wb_dat_i = 32'h12345678;
    wb_we_i  = 1'b1;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    repeat (2) idle_cycle();
    check("rst_pre_cyc", 32'(s_cyc_o), 32'b0100);
    rst_n = 1'b0;
    idle_cycle();
    check("rst_mid_ctrl", {4'd0, s_adr_o, s_we_o, s_sel_o, wb_ack_o, wb_err_o, wb_rty_o,
                           s_cyc_o, s_stb_o, bypass_o, update_o}, 32'd0);
    check("rst_mid_dat", wb_dat_o | s_dat_o, 32'd0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    rst_n    = 1'b1;
    idle_cycle();
    check("rst_bypass", 32'(bypass_o), 32'd0);

    // CSR1 write of 1: ack at cycle 2, single update pulse at cycle 3.
    wb_adr_i = {12'd0, 3'd4, 7'd1};
    wb_dat_i = 32'h1;
    wb_sel_i = 4'hF;
    wb_we_i  = 1'b1;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    upd_cnt  = 0;
    upd_at   = -1;
    ack_at   = -1;
    for (int c = 1; c <= 6; c++) begin
      idle_cycle();
      if (update_o) begin
        upd_cnt++;
        upd_at = c;
      end
      if (wb_ack_o && ack_at < 0) begin
        ack_at   = c;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
      end
    end
    check("upd_ack_lat", ack_at, 2);
    check("upd_pulses", upd_cnt, 1);
    check("upd_cycle", upd_at, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
